// File: rtl/bram_chk_pkg.sv
// Shared types, sizes and the data-pattern generator for the BRAM write/read-back checker.

package bram_chk_pkg;

   localparam int unsigned DEPTH = 16;
   localparam int unsigned AW    = 4;
   localparam int unsigned DW    = 8;

   typedef enum logic [2:0] {
      StIdle,
      StWrite,
      StRead,
      StDrain,
      StDone
   } state_e;

   // Expected contents of one BRAM word for a given selector and address.
   function automatic logic [DW-1:0] pattern(input logic [1:0] sel, input logic [AW-1:0] addr);
      logic [DW-1:0] val;
      case (sel)
         2'd0:    val = {4'h0, addr};
         2'd1:    val = ~{4'h0, addr};
         2'd2:    val = addr[0] ? 8'h55 : 8'hAA;
         default: val = {addr, addr};
      endcase
      return val;
   endfunction

endpackage

// File: rtl/bram_chk_delay.sv
// Valid/address/expected-data shift pipeline matching the BRAM read latency.

module bram_chk_delay
   import bram_chk_pkg::*;
#(
   parameter int unsigned LATENCY = 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in_valid,
   input  logic [AW-1:0] in_addr,
   input  logic [DW-1:0] in_exp,
   output logic          out_valid,
   output logic [AW-1:0] out_addr,
   output logic [DW-1:0] out_exp
);

   logic [LATENCY-1:0] vld_q;
   logic [AW-1:0]      addr_q [LATENCY];
   logic [DW-1:0]      exp_q  [LATENCY];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_q <= '0;
         for (int i = 0; i < int'(LATENCY); i++) begin
            addr_q[i] <= '0;
            exp_q[i]  <= '0;
         end
      end else begin
         vld_q[0]  <= in_valid;
         addr_q[0] <= in_addr;
         exp_q[0]  <= in_exp;
         for (int i = 1; i < int'(LATENCY); i++) begin
            vld_q[i]  <= vld_q[i-1];
            addr_q[i] <= addr_q[i-1];
            exp_q[i]  <= exp_q[i-1];
         end
      end
   end

   assign out_valid = vld_q[LATENCY-1];
   assign out_addr  = addr_q[LATENCY-1];
   assign out_exp   = exp_q[LATENCY-1];

endmodule

// File: rtl/bram_checker.sv
// Writes a selectable pattern to a 16x8 BRAM, reads it back and counts mismatching addresses.

module bram_checker
   import bram_chk_pkg::*;
#(
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic          clka,
   input  logic          rsta_n,
   input  logic          start,
   input  logic [1:0]    pattern_sel,
   output logic          wea,
   output logic [AW-1:0] addra,
   output logic [DW-1:0] dina,
   input  logic [DW-1:0] douta,
   output logic          busy,
   output logic          done,
   output logic          pass,
   output logic [4:0]    err_count,
   output logic [AW-1:0] first_err_addr
);

   localparam logic [AW-1:0] LAST_ADDR  = AW'(DEPTH - 1);
   localparam logic [1:0]    DRAIN_LAST = 2'(READ_LATENCY - 1);

   state_e        state;
   logic [1:0]    sel_q;
   logic [1:0]    drain_cnt_q;

   logic          rd_valid;
   logic [DW-1:0] rd_exp;
   logic          cmp_valid;
   logic [AW-1:0] cmp_addr;
   logic [DW-1:0] cmp_exp;
   logic          mismatch;
   logic [4:0]    err_next;

   // The tag enters the pipeline in the same cycle its address is on addra.
   assign rd_valid = (state == StRead);
   assign rd_exp   = pattern(sel_q, addra);

   bram_chk_delay #(
      .LATENCY (READ_LATENCY)
   ) u_delay (
      .clk       (clka),
      .rst_n     (rsta_n),
      .in_valid  (rd_valid),
      .in_addr   (addra),
      .in_exp    (rd_exp),
      .out_valid (cmp_valid),
      .out_addr  (cmp_addr),
      .out_exp   (cmp_exp)
   );

   assign mismatch = cmp_valid && (douta != cmp_exp);
   assign err_next = err_count + {4'b0, mismatch};

   always_ff @(posedge clka or negedge rsta_n) begin
      if (!rsta_n) begin
         state          <= StIdle;
         sel_q          <= '0;
         drain_cnt_q    <= '0;
         wea            <= 1'b0;
         addra          <= '0;
         dina           <= '0;
         busy           <= 1'b0;
         done           <= 1'b0;
         pass           <= 1'b0;
         err_count      <= '0;
         first_err_addr <= '0;
      end else begin
         if (mismatch) begin
            err_count <= err_next;
            if (err_count == '0) begin
               first_err_addr <= cmp_addr;
            end
         end

         case (state)
            StIdle, StDone: begin
               if (start) begin
                  sel_q          <= pattern_sel;
                  err_count      <= '0;
                  first_err_addr <= '0;
                  done           <= 1'b0;
                  pass           <= 1'b0;
                  busy           <= 1'b1;
                  wea            <= 1'b1;
                  addra          <= '0;
                  dina           <= pattern(pattern_sel, {AW{1'b0}});
                  state          <= StWrite;
               end
            end
            StWrite: begin
               if (addra == LAST_ADDR) begin
                  wea   <= 1'b0;
                  addra <= '0;
                  dina  <= '0;
                  state <= StRead;
               end else begin
                  addra <= addra + AW'(1);
                  dina  <= pattern(sel_q, addra + AW'(1));
               end
            end
            StRead: begin
               addra <= addra + AW'(1);
               if (addra == LAST_ADDR) begin
                  drain_cnt_q <= '0;
                  state       <= StDrain;
               end
            end
            StDrain: begin
               // Last compare lands on this same edge, so pass uses the updated count.
               if (drain_cnt_q == DRAIN_LAST) begin
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  pass  <= (err_next == '0);
                  state <= StDone;
               end else begin
                  drain_cnt_q <= drain_cnt_q + 2'd1;
               end
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_bram_checker.sv
// Directed bench: two checker instances (read latency 1 and 2) each against a behavioural BRAM.

module tb_bram_checker;

   logic       clka = 1'b0;
   logic       rsta_n;
   logic       start1, start2;
   logic [1:0] pattern_sel;

   logic       wea1, wea2;
   logic [3:0] addra1, addra2;
   logic [7:0] dina1, dina2, douta1, douta2;
   logic       busy1, busy2, done1, done2, pass1, pass2;
   logic [4:0] err1, err2;
   logic [3:0] ferr1, ferr2;

   int total = 0;
   int bad   = 0;
   int fault = 0;
   int wr_cnt1 = 0;
   int w0;

   logic [7:0] mem1 [16];
   logic [7:0] mem2 [16];
   logic [7:0] rd1, rd2a, rd2b;
   logic [3:0] ra1;

   always #5 clka = ~clka;

   bram_checker #(.READ_LATENCY(1)) dut (
      .clka(clka), .rsta_n(rsta_n), .start(start1), .pattern_sel(pattern_sel),
      .wea(wea1), .addra(addra1), .dina(dina1), .douta(douta1),
      .busy(busy1), .done(done1), .pass(pass1), .err_count(err1), .first_err_addr(ferr1)
   );

   bram_checker #(.READ_LATENCY(2)) dut2 (
      .clka(clka), .rsta_n(rsta_n), .start(start2), .pattern_sel(pattern_sel),
      .wea(wea2), .addra(addra2), .dina(dina2), .douta(douta2),
      .busy(busy2), .done(done2), .pass(pass2), .err_count(err2), .first_err_addr(ferr2)
   );

   // One-cycle BRAM with optional read faults.
   always @(posedge clka) begin
      if (wea1) begin
         mem1[addra1] <= dina1;
         wr_cnt1      <= wr_cnt1 + 1;
      end
      rd1 <= mem1[addra1];
      ra1 <= addra1;
   end
   assign douta1 = (fault == 2) ? 8'h00 :
                   (fault == 1 && ra1 == 4'd5) ? (rd1 ^ 8'h01) : rd1;

   // Two-cycle BRAM.
   always @(posedge clka) begin
      if (wea2) mem2[addra2] <= dina2;
      rd2a <= mem2[addra2];
      rd2b <= rd2a;
   end
   assign douta2 = rd2b;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run(input bit which, input logic [1:0] sel, input bit poke, input int exp_cyc);
      int   cyc;
      logic prev_busy;
      @(negedge clka);
      if (which) start2 = 1'b1;
      else       start1 = 1'b1;
      pattern_sel = sel;
      @(posedge clka);
      #1;
      check("busy_after_start", which ? busy2 : busy1, 1);
      check("done_cleared", which ? done2 : done1, 0);
      start1 = 1'b0;
      start2 = 1'b0;
      cyc = 0;
      prev_busy = 1'b1;
      while (cyc < 200) begin
         prev_busy = which ? busy2 : busy1;
         @(posedge clka);
         #1;
         cyc++;
         if (poke && cyc == 20) begin
            start1      = 1'b1;
            pattern_sel = ~sel;
         end
         if (poke && cyc == 21) begin
            start1      = 1'b0;
            pattern_sel = sel;
         end
         if (which ? done2 : done1) break;
      end
      check("done_edge", cyc, exp_cyc);
      check("busy_before_done", prev_busy, 1);
      check("busy_at_done", which ? busy2 : busy1, 0);
      repeat (3) @(posedge clka);
      #1;
      check("done_held", which ? done2 : done1, 1);
   endtask

   initial begin
      rsta_n      = 1'b0;
      start1      = 1'b0;
      start2      = 1'b0;
      pattern_sel = 2'd0;
      repeat (3) @(posedge clka);
      #1;
      check("rst_wea", wea1, 0);
      check("rst_addra", addra1, 0);
      check("rst_busy", busy1, 0);
      check("rst_done", done1, 0);
      check("rst_err", err1, 0);
      @(negedge clka);
      rsta_n = 1'b1;
      repeat (2) @(posedge clka);
      #1;
      check("no_autostart", busy1, 0);

      // Clean run, incrementing pattern.
      w0 = wr_cnt1;
      run(1'b0, 2'd0, 1'b0, 33);
      check("sel0_writes", wr_cnt1 - w0, 16);
      check("sel0_mem9", mem1[9], 8'h09);
      check("sel0_pass", pass1, 1);
      check("sel0_err", err1, 0);
      check("sel0_ferr", ferr1, 0);

      // Single bit flip at address 5.
      fault = 1;
      run(1'b0, 2'd3, 1'b0, 33);
      fault = 0;
      check("sel3_mem5", mem1[5], 8'h55);
      check("sel3_err", err1, 1);
      check("sel3_ferr", ferr1, 5);
      check("sel3_pass", pass1, 0);

      // Read data stuck at zero.
      fault = 2;
      run(1'b0, 2'd1, 1'b0, 33);
      fault = 0;
      check("sel1_mem2", mem1[2], 8'hFD);
      check("sel1_err", err1, 16);
      check("sel1_ferr", ferr1, 0);
      check("sel1_pass", pass1, 0);

      // Reset in the middle of the write phase.
      @(negedge clka);
      start1      = 1'b1;
      pattern_sel = 2'd2;
      @(posedge clka);
      @(negedge clka);
      start1 = 1'b0;
      repeat (7) @(posedge clka);
      #1;
      check("mid_addra", addra1, 7);
      check("mid_wea", wea1, 1);
      #2 rsta_n = 1'b0;
      #1;
      check("arst_wea", wea1, 0);
      check("arst_addra", addra1, 0);
      check("arst_dina", dina1, 0);
      check("arst_busy", busy1, 0);
      check("arst_done", done1, 0);
      check("arst_pass", pass1, 0);
      check("arst_err", err1, 0);
      check("arst_ferr", ferr1, 0);
      @(negedge clka);
      rsta_n = 1'b1;
      repeat (3) @(posedge clka);
      #1;
      check("arst_idle", busy1, 0);

      // Full rerun with a stray start in the read phase.
      w0 = wr_cnt1;
      run(1'b0, 2'd2, 1'b1, 33);
      check("sel2_writes", wr_cnt1 - w0, 16);
      check("sel2_mem6", mem1[6], 8'hAA);
      check("sel2_mem7", mem1[7], 8'h55);
      check("sel2_pass", pass1, 1);
      check("sel2_err", err1, 0);

      // Two-cycle read latency.
      run(1'b1, 2'd0, 1'b0, 34);
      check("rl2_mem12", mem2[12], 8'h0C);
      check("rl2_pass", pass2, 1);
      check("rl2_err", err2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
